// File: rtl/modexp_ctrl_if.sv
// Bundle of the host request/response signals and the shared modular-multiplier
// handshake used by modexp_ctrl. The slave view is the controller's.
interface modexp_ctrl_if #(
  parameter int WIDTH = 6,
  parameter int EXP_W = 6
);
  // Host side
  logic             start;
  logic [WIDTH-1:0] msg;
  logic [EXP_W-1:0] exp;
  logic [WIDTH-1:0] modulus;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] result;

  // Multiplier side
  logic             mm_start;
  logic [WIDTH-1:0] mm_a;
  logic [WIDTH-1:0] mm_b;
  logic [WIDTH-1:0] mm_n;
  logic             mm_done;
  logic [WIDTH-1:0] mm_p;

  modport master (
    output start, msg, exp, modulus, mm_done, mm_p,
    input  busy, done, err, result, mm_start, mm_a, mm_b, mm_n
  );

  modport slave (
    input  start, msg, exp, modulus, mm_done, mm_p,
    output busy, done, err, result, mm_start, mm_a, mm_b, mm_n
  );
endinterface

// File: rtl/modexp_ctrl.sv
// Right-to-left square-and-multiply sequencer computing msg^exp mod modulus
// using one shared external modular multiplier through a start/done handshake.
module modexp_ctrl #(
  parameter int WIDTH = 6,
  parameter int EXP_W = 6
) (
  input  logic          clk,
  input  logic          rst,
  modexp_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_MUL, S_WMUL, S_SQR, S_WSQR, S_FIN
  } state_t;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_acc, r_base, r_result, r_mm_a, r_mm_b, r_mm_n;
  logic [EXP_W-1:0] r_e;
  logic             r_err, r_mm_start;
  logic             w_busy, w_done, w_bad_op, w_last_bit;

  assign w_bad_op   = (r_mm_n < WIDTH'(2)) || (r_base >= r_mm_n);
  // Only the current LSB remains: no further squaring is needed.
  assign w_last_bit = (r_e[EXP_W-1:1] == '0);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // NOTE: combinational block uses blocking assignments and assigns every
  // output a default first, so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    w_busy = (r_state != S_IDLE);
    w_done = (r_state == S_FIN);
    unique case (r_state)
      S_IDLE:  if (bus.start) w_next = S_CHECK;
      S_CHECK: begin
        if (w_bad_op || (r_e == '0)) w_next = S_FIN;
        else if (r_e[0])              w_next = S_MUL;
        else                          w_next = S_SQR;
      end
      S_MUL:   w_next = S_WMUL;
      S_WMUL:  if (bus.mm_done) w_next = w_last_bit ? S_FIN : S_SQR;
      S_SQR:   w_next = w_last_bit ? S_FIN : S_WSQR;
      S_WSQR:  if (bus.mm_done) w_next = S_CHECK;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // mm_start is registered so it rises on the same edge that loads mm_a/mm_b.
  // NOTE: sequential state uses non-blocking assignments; every register,
  // including the datapath, is cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc      <= '0;
      r_base     <= '0;
      r_e        <= '0;
      r_result   <= '0;
      r_err      <= 1'b0;
      r_mm_a     <= '0;
      r_mm_b     <= '0;
      r_mm_n     <= '0;
      r_mm_start <= 1'b0;
    end else begin
      r_mm_start <= 1'b0;
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_base <= bus.msg;
          r_e    <= bus.exp;
          r_mm_n <= bus.modulus;
          r_acc  <= WIDTH'(1);
          r_err  <= 1'b0;
        end
        S_CHECK: begin
          if (w_bad_op) begin
            r_err    <= 1'b1;
            r_result <= '0;
          end else if (r_e == '0) begin
            r_result <= r_acc;
          end
        end
        S_MUL: begin
          r_mm_a     <= r_acc;
          r_mm_b     <= r_base;
          r_mm_start <= 1'b1;
        end
        S_WMUL: if (bus.mm_done) begin
          r_acc <= bus.mm_p;
          if (w_last_bit) r_result <= bus.mm_p;
        end
        S_SQR: begin
          if (w_last_bit) begin
            r_result <= r_acc;
          end else begin
            r_mm_a     <= r_base;
            r_mm_b     <= r_base;
            r_mm_start <= 1'b1;
          end
        end
        S_WSQR: if (bus.mm_done) begin
          r_base <= bus.mm_p;
          r_e    <= r_e >> 1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = w_busy;
  assign bus.done     = w_done;
  assign bus.err      = r_err;
  assign bus.result   = r_result;
  assign bus.mm_start = r_mm_start;
  assign bus.mm_a     = r_mm_a;
  assign bus.mm_b     = r_mm_b;
  assign bus.mm_n     = r_mm_n;

endmodule

// File: tb/tb_modexp_ctrl.sv
// Bench for modexp_ctrl: behavioural multiplier with programmable latency and a
// plain-arithmetic exponentiation model for directed and random operations.
module tb_modexp_ctrl;
  localparam int WIDTH = 6;
  localparam int EXP_W = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  modexp_ctrl_if #(.WIDTH(WIDTH), .EXP_W(EXP_W)) bus ();

  modexp_ctrl #(.WIDTH(WIDTH), .EXP_W(EXP_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Multiplier model: product returned mm_lat cycles after mm_start.
  int mm_lat    = 1;
  int mm_cnt    = 0;
  int mm_starts = 0;
  int stab_err  = 0;
  int pa, pb, pn;

  always @(negedge clk) begin
    bus.mm_done = 1'b0;
    if (mm_cnt > 0) begin
      if (bus.busy && (int'(bus.mm_a) != pa || int'(bus.mm_b) != pb)) stab_err++;
      mm_cnt--;
      if (mm_cnt == 0) begin
        bus.mm_done = 1'b1;
        bus.mm_p    = WIDTH'((pa * pb) % pn);
      end
    end
    if (bus.mm_start === 1'b1) begin
      mm_starts++;
      pa     = int'(bus.mm_a);
      pb     = int'(bus.mm_b);
      pn     = int'(bus.mm_n);
      mm_cnt = mm_lat;
    end
  end

  // Reference: repeated multiplication, not square-and-multiply.
  function automatic void ref_model(input int m, input int e, input int n,
                                    output int res, output bit er, output int nops);
    er = (n < 2) || (m >= n);
    res = 0;
    nops = 0;
    if (!er) begin
      res = 1 % n;
      for (int i = 0; i < e; i++) res = (res * m) % n;
      nops = (e == 0) ? 0 : ($countones(e) + $clog2(e + 1) - 1);
    end
  endfunction

  logic [WIDTH-1:0] got_res;
  logic             got_err;
  int               got_cyc, got_starts;
  bit               got_timeout, busy_drop;

  task automatic run_op(input int m, input int e, input int n, input int lat, input bit poke);
    int s0;
    mm_lat = lat;
    @(negedge clk);
    stab_err    = 0;
    s0          = mm_starts;
    bus.start   = 1'b1;
    bus.msg     = WIDTH'(m);
    bus.exp     = EXP_W'(e);
    bus.modulus = WIDTH'(n);
    @(negedge clk);
    bus.start   = 1'b0;
    bus.msg     = WIDTH'($urandom);
    bus.exp     = EXP_W'($urandom);
    bus.modulus = WIDTH'($urandom);
    got_cyc     = 1;
    busy_drop   = 0;
    got_timeout = 1;
    while (got_cyc < 3000) begin
      if (bus.busy !== 1'b1) busy_drop = 1;
      if (bus.done === 1'b1) begin
        got_timeout = 0;
        break;
      end
      if (poke && (got_cyc == 3 || got_cyc == 8)) begin
        bus.start   = 1'b1;
        bus.msg     = WIDTH'(1);
        bus.exp     = EXP_W'(2);
        bus.modulus = WIDTH'(7);
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      got_cyc++;
    end
    bus.start  = 1'b0;
    got_res    = bus.result;
    got_err    = bus.err;
    got_starts = mm_starts - s0;
    n_checks++;
    if (got_timeout) begin
      n_fail++;
      $display("FAIL done_timeout: msg=%0d exp=%0d n=%0d no done within %0d cycles", m, e, n, got_cyc);
    end
  endtask

  task automatic check_op(input string name, input int m, input int e, input int n);
    int er_res, er_ops;
    bit er_err;
    ref_model(m, e, n, er_res, er_err, er_ops);
    n_checks++;
    if (got_res !== WIDTH'(er_res)) begin
      n_fail++;
      $display("FAIL %s result: msg=%0d exp=%0d n=%0d got %0d expected %0d", name, m, e, n, got_res, er_res);
    end
    n_checks++;
    if (got_err !== er_err) begin
      n_fail++;
      $display("FAIL %s err: got %b expected %b", name, got_err, er_err);
    end
    n_checks++;
    if (got_starts != er_ops) begin
      n_fail++;
      $display("FAIL %s mm_start count: got %0d expected %0d", name, got_starts, er_ops);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.msg = '0;
    bus.exp = '0;
    bus.modulus = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.done, bus.err, bus.mm_start} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset flags: got busy/done/err/mm_start=%b expected 0000",
               {bus.busy, bus.done, bus.err, bus.mm_start});
    end
    n_checks++;
    if ({bus.result, bus.mm_a, bus.mm_b, bus.mm_n} !== '0) begin
      n_fail++;
      $display("FAIL reset data: got result=%0d a=%0d b=%0d n=%0d expected all 0",
               bus.result, bus.mm_a, bus.mm_b, bus.mm_n);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    run_op(4, 13, 33, 1, 0);
    check_op("basic", 4, 13, 33);
    n_checks++;
    if (got_res !== WIDTH'(31) || got_starts != 6) begin
      n_fail++;
      $display("FAIL basic_const: got result=%0d starts=%0d expected 31 and 6", got_res, got_starts);
    end
    @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse: got done=%b busy=%b after done expected 0 0", bus.done, bus.busy);
    end
    repeat (4) @(negedge clk);
    n_checks++;
    if (bus.result !== WIDTH'(31) || bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL result_hold: got %0d/%b expected 31/0", bus.result, bus.err);
    end
  endtask

  task automatic test_slow_mul();
    run_op(5, 7, 33, 5, 0);
    check_op("slow", 5, 7, 33);
    n_checks++;
    if (stab_err != 0 || busy_drop) begin
      n_fail++;
      $display("FAIL slow_stability: got %0d operand changes, busy_drop=%0d expected 0 0", stab_err, busy_drop);
    end
  endtask

  task automatic test_exp_zero();
    run_op(9, 0, 33, 1, 0);
    check_op("exp0", 9, 0, 33);
    n_checks++;
    if (got_cyc != 2) begin
      n_fail++;
      $display("FAIL exp0_latency: got done at cycle %0d expected 2", got_cyc);
    end
  endtask

  task automatic test_errors();
    run_op(7, 5, 1, 1, 0);
    check_op("err_n1", 7, 5, 1);
    run_op(40, 3, 33, 1, 0);
    check_op("err_msg", 40, 3, 33);
    n_checks++;
    if (got_err !== 1'b1 || got_res !== '0) begin
      n_fail++;
      $display("FAIL err_const: got err=%b result=%0d expected 1 0", got_err, got_res);
    end
    run_op(4, 13, 33, 1, 0);
    check_op("err_clear", 4, 13, 33);
  endtask

  task automatic test_start_ignored();
    run_op(4, 13, 33, 2, 1);
    check_op("busy_start", 4, 13, 33);
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    bit bad = 0;
    mm_lat = 6;
    @(negedge clk);
    bus.start = 1'b1;
    bus.msg = WIDTH'(5);
    bus.exp = EXP_W'(7);
    bus.modulus = WIDTH'(33);
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (bus.mm_start === 1'b1) seen = 1;
      @(negedge clk);
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL rst_mid_launch: got no mm_start within 20 cycles expected one");
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({bus.busy, bus.done, bus.err, bus.mm_start} !== 4'b0000 ||
        {bus.result, bus.mm_a, bus.mm_b, bus.mm_n} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_values: got busy=%b done=%b err=%b mm_start=%b result=%0d a=%0d b=%0d n=%0d expected all 0",
               bus.busy, bus.done, bus.err, bus.mm_start, bus.result, bus.mm_a, bus.mm_b, bus.mm_n);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.mm_start !== 1'b0 || bus.result !== '0) bad = 1;
    end
    n_checks++;
    if (bad || mm_cnt != 0) begin
      n_fail++;
      $display("FAIL rst_mid_late_done: got activity after late mm_done (bad=%0d pending=%0d) expected idle", bad, mm_cnt);
    end
    run_op(4, 13, 33, 1, 0);
    check_op("rst_mid_rerun", 4, 13, 33);
  endtask

  task automatic test_random();
    for (int k = 0; k < 25; k++) begin
      int n, m, e, lat;
      n   = $urandom_range(2, 63);
      if ($urandom_range(0, 5) == 0) begin
        n = $urandom_range(0, 3);
        m = $urandom_range(0, 63);
      end else begin
        m = $urandom_range(0, n - 1);
      end
      e   = $urandom_range(0, 63);
      lat = $urandom_range(1, 4);
      run_op(m, e, n, lat, 0);
      check_op("random", m, e, n);
      n_checks++;
      if (stab_err != 0 || busy_drop) begin
        n_fail++;
        $display("FAIL random_handshake: msg=%0d exp=%0d n=%0d got %0d operand changes busy_drop=%0d expected 0 0",
                 m, e, n, stab_err, busy_drop);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_slow_mul();
    test_exp_zero();
    test_errors();
    test_start_ignored();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
